// File: rtl/div_iter_pkg.sv
// Shared types and helpers for the iterative radix-2 divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } div_state_t;

    localparam int DIV_WIDTH = 32;
    localparam int NEG_W     = 64;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int DIV_CNT_W = cnt_width(DIV_WIDTH);

    // Operates at NEG_W bits; callers truncate, which keeps the low bits exact.
    function automatic logic [NEG_W-1:0] cond_neg(input logic [NEG_W-1:0] x, input logic neg);
        return neg ? (~x + NEG_W'(1)) : x;
    endfunction

endpackage

// File: rtl/div_iter_if.sv
// Start/busy/valid handshake bundle between the execute stage and div_iter.
interface div_iter_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);
    logic               start;
    logic               cancel;
    logic               sign;
    logic [WIDTH-1:0]   dividend;
    logic [WIDTH-1:0]   divisor;
    logic               busy;
    logic               out_valid;
    logic [2*WIDTH-1:0] result;
    logic               div_by_zero;

    modport master (
        output start, cancel, sign, dividend, divisor,
        input  busy, out_valid, result, div_by_zero
    );

    modport slave (
        input  start, cancel, sign, dividend, divisor,
        output busy, out_valid, result, div_by_zero
    );
endinterface

// File: rtl/div_iter_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   p_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   p_out,
    output logic             q_bit
);
    logic [WIDTH+1:0] shifted;
    logic [WIDTH:0]   diff;
    logic             ge;

    // Compare at full shifted width; the difference itself always fits WIDTH+1 bits.
    always_comb begin
        shifted = {p_in, bit_in};
        ge      = (shifted >= {2'b00, divisor});
        diff    = shifted[WIDTH:0] - {1'b0, divisor};
        p_out   = ge ? diff : shifted[WIDTH:0];
        q_bit   = ge;
    end
endmodule

// File: rtl/div_iter.sv
// Iterative signed/unsigned radix-2 divider with start/busy/valid handshake and cancel.
module div_iter
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic       clk,
    input  logic       resetn,
    div_iter_if.slave  bus
);
    localparam int CW = cnt_width(WIDTH);

    div_state_t state, state_next;

    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     p, p_next;
    logic [WIDTH-1:0]   a_sh, b_mag, raw_dvd;
    logic               q_neg, r_neg, zero_div, q_bit;
    logic               load, step, finish;
    logic               out_valid_q, dbz_q;
    logic [2*WIDTH-1:0] result_q;
    logic [WIDTH-1:0]   dvd_mag, dvs_mag, q_fix, r_fix;

    assign dvd_mag = WIDTH'(cond_neg(NEG_W'(bus.dividend), bus.sign & bus.dividend[WIDTH-1]));
    assign dvs_mag = WIDTH'(cond_neg(NEG_W'(bus.divisor),  bus.sign & bus.divisor[WIDTH-1]));
    assign q_fix   = WIDTH'(cond_neg(NEG_W'(a_sh), q_neg));
    assign r_fix   = WIDTH'(cond_neg(NEG_W'(p[WIDTH-1:0]), r_neg));

    div_step #(.WIDTH(WIDTH)) u_step (
        .p_in    (p),
        .bit_in  (a_sh[WIDTH-1]),
        .divisor (b_mag),
        .p_out   (p_next),
        .q_bit   (q_bit)
    );

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start && !bus.cancel) state_next = CALC;
            CALC:    if (bus.cancel)               state_next = IDLE;
                     else if (cnt == CW'(1))       state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        load   = (state == IDLE) && bus.start && !bus.cancel;
        step   = (state == CALC) && !bus.cancel;
        finish = (state == FIX)  && !bus.cancel;
    end

    // a_sh holds the dividend magnitude and fills with quotient bits as it shifts out.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt         <= '0;
            p           <= '0;
            a_sh        <= '0;
            b_mag       <= '0;
            raw_dvd     <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            zero_div    <= 1'b0;
            out_valid_q <= 1'b0;
            dbz_q       <= 1'b0;
            result_q    <= '0;
        end else begin
            out_valid_q <= finish;
            if (load) begin
                a_sh     <= dvd_mag;
                b_mag    <= dvs_mag;
                raw_dvd  <= bus.dividend;
                q_neg    <= bus.sign & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                r_neg    <= bus.sign & bus.dividend[WIDTH-1];
                zero_div <= (bus.divisor == '0);
                p        <= '0;
                cnt      <= CW'(WIDTH);
            end
            if (step) begin
                p    <= p_next;
                a_sh <= {a_sh[WIDTH-2:0], q_bit};
                cnt  <= cnt - CW'(1);
            end
            if (finish) begin
                result_q <= zero_div ? {{WIDTH{1'b1}}, raw_dvd} : {q_fix, r_fix};
                dbz_q    <= zero_div;
            end
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.out_valid   = out_valid_q;
    assign bus.result      = result_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed corner cases, random operands, cancel and reset.
module tb_div_iter;
    import div_pkg::*;

    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    div_iter_if #(.WIDTH(W)) bus();

    div_iter #(.WIDTH(W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    logic [2*W-1:0] last_exp = '0;

    // Reference: {div_by_zero, quotient, remainder} from plain arithmetic.
    function automatic logic [2*W:0] model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] q, r, minv;
        minv = W'(1) << (W - 1);
        if (b == '0) return {1'b1, {W{1'b1}}, a};
        if (s) begin
            if (a == minv && b == '1) begin
                q = minv;
                r = '0;
            end else begin
                q = W'($signed(a) / $signed(b));
                r = W'($signed(a) % $signed(b));
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        return {1'b0, q, r};
    endfunction

    task automatic idle_inputs();
        bus.start    = 1'b0;
        bus.cancel   = 1'b0;
        bus.sign     = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
    endtask

    // Called at a negedge; returns at the negedge where out_valid is seen (or after a timeout).
    task automatic run_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [2*W-1:0] res, output logic dz,
                           output int lat, output int busy_cycles, output logic busy_at_valid);
        bus.start    = 1'b1;
        bus.sign     = s;
        bus.dividend = a;
        bus.divisor  = b;
        @(negedge clk);
        bus.start   = 1'b0;
        lat         = 0;
        busy_cycles = 0;
        while (!bus.out_valid && lat < 100) begin
            if (bus.busy) busy_cycles++;
            @(negedge clk);
            lat++;
        end
        res           = bus.result;
        dz            = bus.div_by_zero;
        busy_at_valid = bus.busy;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        vectors++; if (bus.busy !== 1'b0)        begin miscompares++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        vectors++; if (bus.out_valid !== 1'b0)   begin miscompares++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
        vectors++; if (bus.result !== '0)        begin miscompares++; $display("FAIL reset_result got %h want 0", bus.result); end
        vectors++; if (bus.div_by_zero !== 1'b0) begin miscompares++; $display("FAIL reset_dbz got %b want 0", bus.div_by_zero); end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic           ts[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [W-1:0]   ta[8] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000,
                                  32'h8000_0000, 32'h1234, 32'd0, 32'hFFFF_FFF9};
        logic [W-1:0]   tb[8] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                                  32'hFFFF_FFFF, 32'd0, 32'd5, 32'd0};
        logic [2*W-1:0] te[8] = '{64'h0000_000E_0000_0002, 64'hFFFF_FFFD_FFFF_FFFF,
                                  64'hFFFF_FFFD_0000_0001, 64'h8000_0000_0000_0000,
                                  64'h0000_0000_8000_0000, 64'hFFFF_FFFF_0000_1234,
                                  64'h0000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFF9};
        logic           tz[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [2*W-1:0] res;
        logic           dz, bav;
        int             lat, bc;
        for (int i = 0; i < 8; i++) begin
            run_div(ts[i], ta[i], tb[i], res, dz, lat, bc, bav);
            last_exp = te[i];
            vectors++; if (res !== te[i]) begin miscompares++; $display("FAIL dir%0d_result got %h want %h", i, res, te[i]); end
            vectors++; if (dz !== tz[i])  begin miscompares++; $display("FAIL dir%0d_dbz got %b want %b", i, dz, tz[i]); end
            vectors++; if (lat !== LAT)   begin miscompares++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, LAT); end
            vectors++; if (bc !== LAT)    begin miscompares++; $display("FAIL dir%0d_busy_cycles got %0d want %0d", i, bc, LAT); end
            vectors++; if (bav !== 1'b0)  begin miscompares++; $display("FAIL dir%0d_busy_at_valid got %b want 0", i, bav); end
            @(negedge clk);
            vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL dir%0d_valid_pulse got %b want 0", i, bus.out_valid); end
        end
    endtask

    task automatic test_random();
        logic [2*W-1:0] res;
        logic [2*W:0]   exp;
        logic [W-1:0]   a, b;
        logic           s, dz, bav;
        int             lat, bc;
        for (int i = 0; i < 60; i++) begin
            s = 1'(($urandom & 1));
            a = W'($urandom);
            case ($urandom_range(0, 6))
                0:       b = '0;
                1:       b = '1;
                2:       b = W'($urandom_range(1, 15));
                3:       b = W'(0) - W'($urandom_range(1, 15));
                default: b = W'($urandom) >> $urandom_range(0, 31);
            endcase
            if ($urandom_range(0, 9) == 0) a = W'(1) << (W - 1);
            if ($urandom_range(0, 19) == 0) a = '0;
            exp = model(s, a, b);
            run_div(s, a, b, res, dz, lat, bc, bav);
            last_exp = exp[2*W-1:0];
            vectors++; if (res !== exp[2*W-1:0]) begin miscompares++; $display("FAIL rnd%0d_result s=%b %h/%h got %h want %h", i, s, a, b, res, exp[2*W-1:0]); end
            vectors++; if (dz !== exp[2*W])      begin miscompares++; $display("FAIL rnd%0d_dbz got %b want %b", i, dz, exp[2*W]); end
            vectors++; if (lat !== LAT)          begin miscompares++; $display("FAIL rnd%0d_latency got %0d want %0d", i, lat, LAT); end
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [2*W-1:0] res;
        logic [2*W:0]   exp;
        logic [W-1:0]   a, b;
        logic           dz, bav;
        int             lat, bc;
        for (int i = 0; i < 4; i++) begin
            a   = W'($urandom);
            b   = W'($urandom_range(1, 1000));
            exp = model(1'b0, a, b);
            run_div(1'b0, a, b, res, dz, lat, bc, bav);
            last_exp = exp[2*W-1:0];
            vectors++; if (res !== exp[2*W-1:0]) begin miscompares++; $display("FAIL b2b%0d_result got %h want %h", i, res, exp[2*W-1:0]); end
            vectors++; if (lat !== LAT)          begin miscompares++; $display("FAIL b2b%0d_latency got %0d want %0d", i, lat, LAT); end
        end
        @(negedge clk);
    endtask

    task automatic test_cancel();
        logic [2*W-1:0] res;
        logic           dz, bav;
        int             lat, bc, valids, changed;
        // cancel together with start in IDLE: start dropped
        bus.start = 1'b1; bus.cancel = 1'b1; bus.dividend = 32'd9; bus.divisor = 32'd3;
        @(negedge clk);
        idle_inputs();
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL cancel_idle_busy got %b want 0", bus.busy); end
        // cancel mid-calculation with a competing start
        bus.start = 1'b1; bus.sign = 1'b0; bus.dividend = 32'd100; bus.divisor = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.start = 1'b1; bus.cancel = 1'b1; bus.dividend = 32'd9; bus.divisor = 32'd3;
        @(negedge clk);
        idle_inputs();
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL cancel_busy got %b want 0", bus.busy); end
        valids  = 0;
        changed = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.out_valid) valids++;
            if (bus.result !== last_exp) changed++;
            @(negedge clk);
        end
        vectors++; if (valids !== 0)  begin miscompares++; $display("FAIL cancel_no_valid got %0d want 0", valids); end
        vectors++; if (changed !== 0) begin miscompares++; $display("FAIL cancel_result_held got %0d changes want 0", changed); end
        run_div(1'b0, 32'd9, 32'd3, res, dz, lat, bc, bav);
        last_exp = 64'h0000_0003_0000_0000;
        vectors++; if (res !== last_exp) begin miscompares++; $display("FAIL cancel_after_result got %h want %h", res, last_exp); end
        vectors++; if (lat !== LAT)      begin miscompares++; $display("FAIL cancel_after_latency got %0d want %0d", lat, LAT); end
        @(negedge clk);
    endtask

    task automatic test_start_while_busy();
        int lat, valids;
        bus.start = 1'b1; bus.sign = 1'b0; bus.dividend = 32'd50; bus.divisor = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            bus.start = (lat == 4);
            if (lat == 4) begin bus.dividend = 32'd1; bus.divisor = 32'd1; end
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        last_exp = 64'h0000_000A_0000_0000;
        vectors++; if (lat !== LAT)             begin miscompares++; $display("FAIL busy_start_latency got %0d want %0d", lat, LAT); end
        vectors++; if (bus.result !== last_exp) begin miscompares++; $display("FAIL busy_start_result got %h want %h", bus.result, last_exp); end
        valids = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.out_valid) valids++;
        end
        vectors++; if (valids !== 0) begin miscompares++; $display("FAIL busy_start_extra_valid got %0d want 0", valids); end
    endtask

    task automatic test_reset_mid();
        logic [2*W-1:0] res;
        logic           dz, bav;
        int             lat, bc;
        bus.start = 1'b1; bus.sign = 1'b0; bus.dividend = 32'd50; bus.divisor = 32'd5;
        @(negedge clk);
        idle_inputs();
        repeat (19) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        vectors++; if (bus.busy !== 1'b0)        begin miscompares++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
        vectors++; if (bus.out_valid !== 1'b0)   begin miscompares++; $display("FAIL midrst_valid got %b want 0", bus.out_valid); end
        vectors++; if (bus.result !== '0)        begin miscompares++; $display("FAIL midrst_result got %h want 0", bus.result); end
        vectors++; if (bus.div_by_zero !== 1'b0) begin miscompares++; $display("FAIL midrst_dbz got %b want 0", bus.div_by_zero); end
        @(negedge clk);
        run_div(1'b0, 32'd0, 32'd5, res, dz, lat, bc, bav);
        vectors++; if (res !== '0)  begin miscompares++; $display("FAIL midrst_zero_result got %h want 0", res); end
        vectors++; if (lat !== LAT) begin miscompares++; $display("FAIL midrst_zero_latency got %0d want %0d", lat, LAT); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_cancel();
        test_start_while_busy();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
